// File: rtl/flash_pkg.sv
// Shared state encoding and default timing for the flash sequencer.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SWEEP_OUT = 3'd1,
    HOLD_OUT  = 3'd2,
    SWEEP_IN  = 3'd3,
    HOLD_IN   = 3'd4
  } state_t;

  localparam int STEP_CYCLES_DEF = 10;
  localparam int SWEEP_STEPS_DEF = 3;
  localparam int PAUSE_STEPS_DEF = 2;

endpackage

// File: rtl/flash_sequencer_step_timer.sv
// Free-running step counter; tick is high on the last cycle of each step.
module step_timer
  import flash_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/flash_sequencer.sv
// Sweeps a shifter outward and back home with timed steps and end holds.
// Pulse handshake: shift_left/shift_right are single-cycle strobes, no back-pressure.
module flash_sequencer
  import flash_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int SWEEP_STEPS = SWEEP_STEPS_DEF,
  parameter int PAUSE_STEPS = PAUSE_STEPS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       is_flash_1,
  output logic       shift_left,
  output logic       shift_right,
  output logic [3:0] pos,
  output logic       sweep_done,
  output state_t     state
);

  localparam logic [3:0] POS_MAX    = 4'(SWEEP_STEPS);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_STEPS - 1);
  localparam state_t     END_OUT    = (PAUSE_STEPS == 0) ? SWEEP_IN  : HOLD_OUT;
  localparam state_t     END_IN     = (PAUSE_STEPS == 0) ? SWEEP_OUT : HOLD_IN;

  state_t     state_next;
  logic       tick;
  logic       dir;
  logic [7:0] pause_count;
  logic       pause_last;
  logic       pulse_out;
  logic       pulse_in;
  logic       done_next;

  // Counter restarts on every IDLE exit so the first pulse lands a full step later.
  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign pause_last = (pause_count == PAUSE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = (pos == 4'd0) ? SWEEP_OUT : SWEEP_IN;
      SWEEP_OUT: if (pos >= POS_MAX || (tick && pos == POS_MAX - 4'd1)) state_next = END_OUT;
      HOLD_OUT:  if (tick && pause_last) state_next = SWEEP_IN;
      SWEEP_IN:  if (pos == 4'd0 || (tick && pos == 4'd1)) state_next = END_IN;
      HOLD_IN:   if (tick && pause_last) state_next = SWEEP_OUT;
      default:   state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  always_comb begin
    pulse_out = enable && (state == SWEEP_OUT) && tick && (pos < POS_MAX);
    pulse_in  = enable && (state == SWEEP_IN)  && tick && (pos != 4'd0);
    done_next = pulse_in && (pos == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_left  <= 1'b0;
      shift_right <= 1'b0;
      sweep_done  <= 1'b0;
      pos         <= 4'd0;
      dir         <= 1'b1;
      pause_count <= 8'd0;
    end else begin
      // dir=1 maps outward onto shift_right, inward onto shift_left.
      shift_right <= (pulse_out && dir) || (pulse_in && !dir);
      shift_left  <= (pulse_out && !dir) || (pulse_in && dir);
      sweep_done  <= done_next;
      if (pulse_out) pos <= pos + 4'd1;
      else if (pulse_in) pos <= pos - 4'd1;
      if (state == IDLE && enable) dir <= is_flash_1;
      if (state != state_next) pause_count <= 8'd0;
      else if (tick && (state == HOLD_OUT || state == HOLD_IN)) pause_count <= pause_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_flash_sequencer.sv
// Directed bench: two sequencers each driving a behavioural shifter.
module tb_flash_sequencer;
  import flash_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sl1, sr1, sd1, sl2, sr2, sd2;
  logic [3:0] pos1, pos2;
  state_t     st1, st2;
  logic [8:0] sh1, sh2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_sequencer #(.STEP_CYCLES(4), .SWEEP_STEPS(3), .PAUSE_STEPS(2)) u_flash1 (
    .clk(clk), .reset(rst), .enable(en), .is_flash_1(1'b1),
    .shift_left(sl1), .shift_right(sr1), .pos(pos1), .sweep_done(sd1), .state(st1)
  );

  flash_sequencer #(.STEP_CYCLES(4), .SWEEP_STEPS(3), .PAUSE_STEPS(2)) u_flash2 (
    .clk(clk), .reset(rst), .enable(en), .is_flash_1(1'b0),
    .shift_left(sl2), .shift_right(sr2), .pos(pos2), .sweep_done(sd2), .state(st2)
  );

  // Shifter model: shift_right moves the lit bit up, shift_left moves it down.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh1 <= 9'd32;
      sh2 <= 9'd32;
    end else begin
      if (sr1) sh1 <= sh1 << 1;
      else if (sl1) sh1 <= sh1 >> 1;
      if (sr2) sh2 <= sh2 << 1;
      else if (sl2) sh2 <= sh2 >> 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    cyc(2);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    int np1, np2, nd1, nlow, nsl, nsr;

    // Reset state
    rst = 1'b1;
    en  = 1'b0;
    cyc(2);
    chk("reset_pos1", 32'(pos1), 0);
    chk("reset_pos2", 32'(pos2), 0);
    chk("reset_pulses1", {30'd0, sl1, sr1}, 0);
    chk("reset_done1", 32'(sd1), 0);
    chk("reset_state1", 32'(st1), 32'(IDLE));
    chk("reset_sh1", 32'(sh1), 32);
    rst = 1'b0;
    en  = 1'b1;

    // Full sweeps with enable held for 80 cycles
    np1 = 0; np2 = 0; nd1 = 0;
    for (int k = 1; k <= 80; k++) begin
      cyc(1);
      chk("exclusive1", 32'(sl1 & sr1), 0);
      chk("exclusive2", 32'(sl2 & sr2), 0);
      np1 += int'(sl1) + int'(sr1);
      np2 += int'(sl2) + int'(sr2);
      if (k <= 40) nd1 += int'(sd1);
      case (k)
        4:  chk("no_pulse_before_step", {30'd0, sl1, sr1}, 0);
        5:  begin chk("first_pulse_sr1", 32'(sr1), 1); chk("first_pulse_sl2", 32'(sl2), 1); chk("pos1_k5", 32'(pos1), 1); end
        6:  begin chk("sh1_k6", 32'(sh1), 64);  chk("sh2_k6", 32'(sh2), 16); end
        10: begin chk("sh1_k10", 32'(sh1), 128); chk("sh2_k10", 32'(sh2), 8); end
        14: begin chk("sh1_k14", 32'(sh1), 256); chk("sh2_k14", 32'(sh2), 4); chk("pos1_k14", 32'(pos1), 3); end
        25: begin chk("hold_sh1_k25", 32'(sh1), 256); chk("first_in_sl1", 32'(sl1), 1); end
        26: begin chk("sh1_k26", 32'(sh1), 128); chk("sh2_k26", 32'(sh2), 8); end
        30: begin chk("sh1_k30", 32'(sh1), 64);  chk("sh2_k30", 32'(sh2), 16); end
        33: begin chk("done1_k33", 32'(sd1), 1); chk("pos1_k33", 32'(pos1), 0); end
        34: begin chk("sh1_k34", 32'(sh1), 32);  chk("sh2_k34", 32'(sh2), 32); end
        44: chk("no_pulse_k44", {30'd0, sl1, sr1}, 0);
        45: chk("period_sr1_k45", 32'(sr1), 1);
        default: ;
      endcase
    end
    chk("pulse_count1", 32'(np1), 12);
    chk("pulse_count2", 32'(np2), 12);
    chk("done_count1", 32'(nd1), 1);

    // Enable dropped at pos=2, re-raised 20 cycles later
    do_reset();
    cyc(10);
    chk("pause_pos1", 32'(pos1), 2);
    chk("pause_sh1", 32'(sh1), 128);
    en = 1'b0;
    nlow = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      nlow += int'(sl1) + int'(sr1);
    end
    chk("low_pulses1", 32'(nlow), 0);
    chk("low_pos1", 32'(pos1), 2);
    chk("low_sh1", 32'(sh1), 128);
    chk("low_state1", 32'(st1), 32'(IDLE));
    en = 1'b1;
    nsl = 0; nsr = 0;
    for (int q = 1; q <= 21; q++) begin
      cyc(1);
      if (q <= 20) begin
        nsl += int'(sl1);
        nsr += int'(sr1);
      end
      case (q)
        5:  chk("resume_sl1_q5", 32'(sl1), 1);
        9:  chk("resume_done_q9", 32'(sd1), 1);
        10: chk("resume_home_q10", 32'(sh1), 32);
        21: chk("resume_out_q21", 32'(sr1), 1);
        default: ;
      endcase
    end
    chk("resume_sl_count", 32'(nsl), 2);
    chk("resume_sr_count", 32'(nsr), 0);

    // Reset on the cycle a pulse is due
    do_reset();
    cyc(8);
    chk("prereset_sh1", 32'(sh1), 64);
    rst = 1'b1;
    cyc(1);
    chk("rst_no_pulse", {30'd0, sl1, sr1}, 0);
    chk("rst_pos1", 32'(pos1), 0);
    chk("rst_sh1", 32'(sh1), 32);
    chk("rst_done1", 32'(sd1), 0);
    rst = 1'b0;
    en  = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_sequencer.md
FLASH_SEQUENCER -- requirements
Module: flash_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 10, clock cycles per step tick (min 2).
REQ-002 SHALL have parameter SWEEP_STEPS, default 3, shift pulses per half-sweep (min 1, max 15).
REQ-003 SHALL have parameter PAUSE_STEPS, default 2, ticks held at each sweep end (0 = no hold).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run sweep when high.
REQ-007 SHALL have port is_flash_1  input  1  1: outward = shift_right, 0: outward = shift_left.
REQ-008 SHALL have port shift_left  output  1  one-cycle pulse to the shifter's shift_left.
REQ-009 SHALL have port shift_right  output  1  one-cycle pulse to the shifter's shift_right.
REQ-010 SHALL have port pos  output  4  steps currently away from home (0..SWEEP_STEPS).
REQ-011 SHALL have port sweep_done  output  1  one-cycle pulse when pos returns to 0 from an inward sweep.

Function
REQ-012 SHALL implement states IDLE, SWEEP_OUT, HOLD_OUT, SWEEP_IN, HOLD_IN.
REQ-013 SHALL run a step counter 0..STEP_CYCLES-1; tick = counter at STEP_CYCLES-1; counter cleared on every IDLE exit.
REQ-014 IDLE with enable sampled high: SHALL latch is_flash_1 as dir and go to SWEEP_OUT if pos=0, else SWEEP_IN.
REQ-015 is_flash_1 SHALL be sampled only on IDLE exit; changes mid-sweep ignored.
REQ-016 SWEEP_OUT on tick: SHALL register one outward pulse and increment pos; at pos=SWEEP_STEPS go to HOLD_OUT.
REQ-017 HOLD_OUT: SHALL emit no pulses for PAUSE_STEPS ticks, then go to SWEEP_IN (immediately if PAUSE_STEPS=0).
REQ-018 SWEEP_IN on tick: SHALL register one inward pulse and decrement pos; at pos=0 assert sweep_done and go to HOLD_IN.
REQ-019 HOLD_IN: SHALL wait PAUSE_STEPS ticks, then go to SWEEP_OUT.
REQ-020 First pulse SHALL appear on the output STEP_CYCLES edges after the edge that leaves IDLE; later pulses every STEP_CYCLES cycles.
REQ-021 shift_left and shift_right SHALL be registered, one cycle wide, never high together.
REQ-022 pos SHALL saturate at 0 and SWEEP_STEPS; no pulse issued beyond either bound.
REQ-023 enable sampled low in any state SHALL go to IDLE on that edge, suppress any pending pulse, and retain pos.
REQ-024 Re-enable with pos>0 SHALL sweep inward first (REQ-014), so the shifter always returns home before a new outward sweep.
REQ-025 Full period with enable held SHALL be (2*SWEEP_STEPS + 2*PAUSE_STEPS)*STEP_CYCLES cycles.

Reset
REQ-026 reset SHALL dominate enable and force state IDLE, counter 0, pos 0, dir 1.
REQ-027 reset SHALL force shift_left 0, shift_right 0 and sweep_done 0 on the following edge.
REQ-028 Reset asserted mid-sweep SHALL abandon the sweep with no further pulses; the shifter resets alongside on the shared reset.

Structure
REQ-029 State encoding and parameter defaults SHALL live in shared package flash_pkg.
REQ-030 The step counter SHALL be a sub-module step_timer with inputs clk, reset, clear and output tick.

Verification
REQ-031 Bench SHALL instantiate two sequencers, each driving a shifter instance (is_flash_1=1 and 0), with STEP_CYCLES=4, SWEEP_STEPS=3, PAUSE_STEPS=2.
REQ-032 Flash1: enable high from reset -> shifter out 32,64,128,256 at 4-cycle spacing, held 8 cycles, then 128,64,32; sweep_done pulses once.
REQ-033 Flash2: same stimulus -> shifter out 32,16,8,4, held 8 cycles, then 8,16,32.
REQ-034 Enable held 80 cycles -> exactly 12 pulses per sequencer, never both shift outputs high, period 40 cycles.
REQ-035 Flash1: enable dropped after 2nd pulse (out=128, pos=2), re-raised 20 cycles later -> no pulses while low; then 2 shift_left pulses back to 32, then an outward sweep.
REQ-036 Flash1: reset asserted on the cycle a pulse is due -> no pulse; pos=0 and shifter out=32 on the next cycle.
